ro_deserializer: RTL and testbench



---
 rtl/ro_pkg.sv | 27 ++
 rtl/ro_packer.sv | 63 ++++++
 rtl/ro_deserializer.sv | 160 ++++++++++++++++
 tb/tb_ro_deserializer.sv | 220 ++++++++++++++++++++++
 4 files changed

// File: rtl/ro_pkg.sv
// Shared constants and the slot-owner decode for the readout deserializer.
//   NCH  : default number of readout channels (gray-counter width)
//   WORD : default samples per output word
//   CW   : default channel-index width
//   slot_owner(s, nch) : trailing-zero count of s; the all-zero slot belongs to nch-1
package ro_pkg;

  localparam int unsigned NCH  = 17;
  localparam int unsigned WORD = 8;
  localparam int unsigned CW   = $clog2(NCH);

  // Channel whose gray bit toggled to produce slot value s (only the low nch bits matter)
  function automatic int unsigned slot_owner(input logic [31:0] s, input int unsigned nch);
    int unsigned r;
    logic        found;
    r     = nch - 1;
    found = 1'b0;
    for (int unsigned i = 0; i < 32; i++) begin
      if (!found && (i < nch) && s[i]) begin
        r     = i;
        found = 1'b1;
      end
    end
    return r;
  endfunction

endpackage

// File: rtl/ro_packer.sv
// Per-channel sample packer: shifts sample pairs into a WORD-bit word at the fill index.
//   clk, reset       : clock, asynchronous active-high reset
//   load             : a sample pair for this channel is present this cycle
//   pol, pol_eve     : the sample pair
//   word_pol_c       : packed pol word including this cycle's sample (valid with done_c)
//   word_pol_eve_c   : packed pol_eve word including this cycle's sample
//   done_c           : this cycle's sample completes the word
module ro_packer #(
  parameter int unsigned WORD = 8
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            load,
  input  logic            pol,
  input  logic            pol_eve,
  output logic [WORD-1:0] word_pol_c,
  output logic [WORD-1:0] word_pol_eve_c,
  output logic            done_c
);

  localparam int unsigned FW = $clog2(WORD);

  logic [FW-1:0]   fill_q, fill_d;
  logic [WORD-1:0] pol_q, pol_d;
  logic [WORD-1:0] eve_q, eve_d;

  // Insert the sample at the fill index; a completed word clears the packer
  always_comb begin
    fill_d         = fill_q;
    pol_d          = pol_q;
    eve_d          = eve_q;
    word_pol_c     = pol_q;
    word_pol_eve_c = eve_q;
    done_c         = 1'b0;
    if (load) begin
      word_pol_c[fill_q]     = pol;
      word_pol_eve_c[fill_q] = pol_eve;
      if (fill_q == FW'(WORD - 1)) begin
        done_c = 1'b1;
        fill_d = '0;
        pol_d  = '0;
        eve_d  = '0;
      end else begin
        fill_d = fill_q + FW'(1);
        pol_d  = word_pol_c;
        eve_d  = word_pol_eve_c;
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      fill_q <= '0;
      pol_q  <= '0;
      eve_q  <= '0;
    end else begin
      fill_q <= fill_d;
      pol_q  <= pol_d;
      eve_q  <= eve_d;
    end
  end

endmodule

// File: rtl/ro_deserializer.sv
// Readout deserializer: samples the shared pol/pol_eve lines each enabled clock, attributes
// each sample to the channel owning the current slot, packs WORD samples per channel and
// presents completed words on a valid/ready stream.
//   clk, reset             : global readout clock, asynchronous active-high reset
//   en                     : slot advance enable (mirrors gray counter enable)
//   bus_pol, bus_pol_eve   : shared readout lines
//   out_ready              : consumer accepts the word
//   out_valid, out_chan    : word available, owning channel
//   out_pol, out_pol_eve   : packed samples, first sample in bit 0
//   overflow               : sticky, a completed word was dropped
module ro_deserializer #(
  parameter int unsigned NCH  = 17,
  parameter int unsigned WORD = 8,
  parameter int unsigned CW   = $clog2(NCH)
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            en,
  input  logic            bus_pol,
  input  logic            bus_pol_eve,
  input  logic            out_ready,
  output logic            out_valid,
  output logic [CW-1:0]   out_chan,
  output logic [WORD-1:0] out_pol,
  output logic [WORD-1:0] out_pol_eve,
  output logic            overflow
);

  import ro_pkg::*;

  logic [NCH-1:0]  cnt_q, cnt_d;
  logic [NCH-1:0]  slot_c;
  logic [CW-1:0]   owner_c;

  logic            v1_q, v1_d;
  logic [CW-1:0]   ch1_q, ch1_d;
  logic            pol1_q, pol1_d;
  logic            eve1_q, eve1_d;

  logic [NCH-1:0]  load_c;
  logic [NCH-1:0]  done_c;
  logic [WORD-1:0] wpol_c [NCH];
  logic [WORD-1:0] weve_c [NCH];

  logic            cmp_c;
  logic [CW-1:0]   cmp_chan_c;
  logic [WORD-1:0] cmp_pol_c;
  logic [WORD-1:0] cmp_eve_c;

  logic            out_valid_q, out_valid_d;
  logic [CW-1:0]   out_chan_q, out_chan_d;
  logic [WORD-1:0] out_pol_q, out_pol_d;
  logic [WORD-1:0] out_eve_q, out_eve_d;
  logic            overflow_q, overflow_d;

  // Slot is the post-increment count; its trailing-zero count names the owning channel
  assign slot_c  = cnt_q + NCH'(1);
  assign owner_c = CW'(slot_owner(32'(slot_c), NCH));

  // Stage 1: advance the slot and capture the bus pair with its owner
  always_comb begin
    cnt_d  = cnt_q;
    v1_d   = 1'b0;
    ch1_d  = ch1_q;
    pol1_d = pol1_q;
    eve1_d = eve1_q;
    if (en) begin
      cnt_d  = slot_c;
      v1_d   = 1'b1;
      ch1_d  = owner_c;
      pol1_d = bus_pol;
      eve1_d = bus_pol_eve;
    end
  end

  // Stage 2: one packer per channel, only the captured owner loads
  for (genvar i = 0; i < NCH; i++) begin : g_pack
    assign load_c[i] = v1_q && (ch1_q == CW'(i));

    ro_packer #(.WORD(WORD)) u_packer (
      .clk            (clk),
      .reset          (reset),
      .load           (load_c[i]),
      .pol            (pol1_q),
      .pol_eve        (eve1_q),
      .word_pol_c     (wpol_c[i]),
      .word_pol_eve_c (weve_c[i]),
      .done_c         (done_c[i])
    );
  end

  // Completion mux: only the loaded packer can finish, so at most one done bit is set
  always_comb begin
    cmp_c      = |done_c;
    cmp_chan_c = '0;
    cmp_pol_c  = '0;
    cmp_eve_c  = '0;
    for (int unsigned i = 0; i < NCH; i++) begin
      if (done_c[i]) begin
        cmp_chan_c = CW'(i);
        cmp_pol_c  = wpol_c[i];
        cmp_eve_c  = weve_c[i];
      end
    end
  end

  // Output register: load when free or being drained, otherwise drop and flag
  always_comb begin
    out_valid_d = out_valid_q;
    out_chan_d  = out_chan_q;
    out_pol_d   = out_pol_q;
    out_eve_d   = out_eve_q;
    overflow_d  = overflow_q;
    if (cmp_c) begin
      if (!out_valid_q || out_ready) begin
        out_valid_d = 1'b1;
        out_chan_d  = cmp_chan_c;
        out_pol_d   = cmp_pol_c;
        out_eve_d   = cmp_eve_c;
      end else begin
        overflow_d = 1'b1;
      end
    end else if (out_valid_q && out_ready) begin
      out_valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cnt_q       <= '0;
      v1_q        <= 1'b0;
      ch1_q       <= '0;
      pol1_q      <= 1'b0;
      eve1_q      <= 1'b0;
      out_valid_q <= 1'b0;
      out_chan_q  <= '0;
      out_pol_q   <= '0;
      out_eve_q   <= '0;
      overflow_q  <= 1'b0;
    end else begin
      cnt_q       <= cnt_d;
      v1_q        <= v1_d;
      ch1_q       <= ch1_d;
      pol1_q      <= pol1_d;
      eve1_q      <= eve1_d;
      out_valid_q <= out_valid_d;
      out_chan_q  <= out_chan_d;
      out_pol_q   <= out_pol_d;
      out_eve_q   <= out_eve_d;
      overflow_q  <= overflow_d;
    end
  end

  assign out_valid   = out_valid_q;
  assign out_chan    = out_chan_q;
  assign out_pol     = out_pol_q;
  assign out_pol_eve = out_eve_q;
  assign overflow    = overflow_q;

endmodule

// File: tb/tb_ro_deserializer.sv
// Directed bench for ro_deserializer: default 17-channel instance plus a 4-channel
// instance for the slot-counter wrap case. Edge n is the n-th clock after reset release.
module tb_ro_deserializer;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       en = 1'b0;
  logic       bus_pol = 1'b0;
  logic       bus_pol_eve = 1'b0;
  logic       out_ready = 1'b0;

  logic       out_valid;
  logic [4:0] out_chan;
  logic [7:0] out_pol;
  logic [7:0] out_pol_eve;
  logic       overflow;

  logic       out_valid4;
  logic [1:0] out_chan4;
  logic [7:0] out_pol4;
  logic [7:0] out_pol_eve4;
  logic       overflow4;

  int checks = 0;
  int failures = 0;
  int edge_n = 0;

  always #5 clk = ~clk;

  ro_deserializer u_dut (
    .clk         (clk),
    .reset       (reset),
    .en          (en),
    .bus_pol     (bus_pol),
    .bus_pol_eve (bus_pol_eve),
    .out_ready   (out_ready),
    .out_valid   (out_valid),
    .out_chan    (out_chan),
    .out_pol     (out_pol),
    .out_pol_eve (out_pol_eve),
    .overflow    (overflow)
  );

  ro_deserializer #(.NCH(4), .WORD(8), .CW(2)) u_dut4 (
    .clk         (clk),
    .reset       (reset),
    .en          (en),
    .bus_pol     (bus_pol),
    .bus_pol_eve (bus_pol_eve),
    .out_ready   (out_ready),
    .out_valid   (out_valid4),
    .out_chan    (out_chan4),
    .out_pol     (out_pol4),
    .out_pol_eve (out_pol_eve4),
    .overflow    (overflow4)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (edge %0d)", tag, got, exp, edge_n);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
    edge_n++;
  endtask

  task automatic do_reset();
    reset       = 1'b1;
    en          = 1'b0;
    bus_pol     = 1'b0;
    bus_pol_eve = 1'b0;
    @(posedge clk);
    @(posedge clk);
    #1;
    reset  = 1'b0;
    edge_n = 0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int first;
    logic [7:0] w;

    // Reset state
    repeat (3) @(posedge clk);
    #1;
    chk("rst_valid", 32'(out_valid), 32'd0);
    chk("rst_chan", 32'(out_chan), 32'd0);
    chk("rst_pol", 32'(out_pol), 32'd0);
    chk("rst_eve", 32'(out_pol_eve), 32'd0);
    chk("rst_ovf", 32'(overflow), 32'd0);
    chk("rst_valid4", 32'(out_valid4), 32'd0);
    reset = 1'b0;
    repeat (6) step();
    chk("idle_valid", 32'(out_valid), 32'd0);
    chk("idle_ovf", 32'(overflow), 32'd0);

    // Constant bus: channel 0 word after slot 15, one cycle only
    do_reset();
    out_ready = 1'b1;
    bus_pol   = 1'b1;
    en        = 1'b1;
    for (int e = 1; e <= 17; e++) begin
      step();
      if (e == 15) chk("const_pre_valid", 32'(out_valid), 32'd0);
      if (e == 16) begin
        chk("const_valid", 32'(out_valid), 32'd1);
        chk("const_chan", 32'(out_chan), 32'd0);
        chk("const_pol", 32'(out_pol), 32'hFF);
        chk("const_eve", 32'(out_pol_eve), 32'h00);
      end
      if (e == 17) chk("const_post_valid", 32'(out_valid), 32'd0);
    end

    // Owner decode: pol high only in channel-3 slots
    do_reset();
    out_ready = 1'b1;
    en        = 1'b1;
    first     = 0;
    for (int e = 1; e <= 125; e++) begin
      bus_pol = ((e % 16) == 8);
      step();
      if (out_valid) begin
        if (out_chan == 5'd3) begin
          chk("own_ch3_pol", 32'(out_pol), 32'hFF);
          if (first == 0) first = e;
        end else begin
          chk("own_low_pol", 32'(out_pol), 32'h00);
        end
      end
    end
    chk("own_ch3_edge", 32'(first), 32'd121);

    // Wrap on the 4-channel instance: slot 0 belongs to channel 3
    do_reset();
    out_ready = 1'b1;
    bus_pol   = 1'b1;
    en        = 1'b1;
    first     = 0;
    w         = 8'h00;
    for (int e = 1; e <= 70; e++) begin
      step();
      if (out_valid4 && (out_chan4 == 2'd3) && (first == 0)) begin
        first = e;
        w     = out_pol4;
      end
    end
    chk("wrap_ch3_edge", 32'(first), 32'd65);
    chk("wrap_ch3_pol", 32'(w), 32'hFF);

    // Backpressure: channel-0 word held, channel-1 word dropped
    do_reset();
    out_ready = 1'b0;
    bus_pol   = 1'b1;
    en        = 1'b1;
    for (int e = 1; e <= 30; e++) begin
      bus_pol_eve = ((e % 4) == 1);
      step();
      if (e == 16) begin
        chk("bp_valid", 32'(out_valid), 32'd1);
        chk("bp_chan", 32'(out_chan), 32'd0);
        chk("bp_ovf_early", 32'(overflow), 32'd0);
      end
      if (e == 30) chk("bp_ovf_pre", 32'(overflow), 32'd0);
    end
    en = 1'b0;
    step();
    chk("bp_ovf", 32'(overflow), 32'd1);
    chk("bp_hold_valid", 32'(out_valid), 32'd1);
    chk("bp_hold_chan", 32'(out_chan), 32'd0);
    chk("bp_hold_pol", 32'(out_pol), 32'hFF);
    chk("bp_hold_eve", 32'(out_pol_eve), 32'h55);
    out_ready = 1'b1;
    step();
    chk("bp_drain_valid", 32'(out_valid), 32'd0);
    chk("bp_drain_ovf", 32'(overflow), 32'd1);

    // Reset mid-operation with a pending word and overflow set
    do_reset();
    out_ready   = 1'b0;
    bus_pol     = 1'b1;
    bus_pol_eve = 1'b1;
    en          = 1'b1;
    repeat (50) step();
    chk("mid_pre_valid", 32'(out_valid), 32'd1);
    chk("mid_pre_ovf", 32'(overflow), 32'd1);
    reset = 1'b1;
    #1;
    chk("mid_rst_valid", 32'(out_valid), 32'd0);
    chk("mid_rst_ovf", 32'(overflow), 32'd0);
    chk("mid_rst_pol", 32'(out_pol), 32'd0);
    do_reset();
    out_ready = 1'b1;
    en        = 1'b1;
    for (int e = 1; e <= 16; e++) begin
      step();
      if (e == 15) chk("mid_pre16_valid", 32'(out_valid), 32'd0);
      if (e == 16) begin
        chk("mid_valid", 32'(out_valid), 32'd1);
        chk("mid_chan", 32'(out_chan), 32'd0);
        chk("mid_pol", 32'(out_pol), 32'h00);
        chk("mid_eve", 32'(out_pol_eve), 32'h00);
      end
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
